sdram_prefetch_buffer: RTL and testbench

- Line-prefetch read buffer between the Wishbone request adapter and the SDRAM controller.
- On a read miss it fills a single DEPTH-word line, critical word first, through the controller's in_valid/busy/out_valid handshake.
- Read hits return in 1 cycle without touching SDRAM.
- Writes are posted through to the controller and update the buffered copy when the line matches.

---
 rtl/sdram_prefetch_buffer_if.sv | 30 +++
 rtl/sdram_prefetch_buffer.sv | 149 ++++++++++++++
 tb/tb_sdram_prefetch_buffer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sdram_prefetch_buffer_if.sv
// Request/response and SDRAM-controller handshake bundle for the prefetch buffer.
// The slave view belongs to the buffer; the master view belongs to its environment.
interface sdram_prefetch_buffer_if #(
    parameter int ADDR_W = 23
) ();
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] ctrl_addr;
    logic              ctrl_rw;
    logic [31:0]       ctrl_wdata;
    logic              ctrl_in_valid;
    logic              ctrl_busy;
    logic [31:0]       ctrl_rdata;
    logic              ctrl_out_valid;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, ctrl_busy, ctrl_rdata, ctrl_out_valid,
        output req_ready, rsp_valid, rsp_rdata, ctrl_addr, ctrl_rw, ctrl_wdata, ctrl_in_valid
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, ctrl_busy, ctrl_rdata, ctrl_out_valid,
        input  req_ready, rsp_valid, rsp_rdata, ctrl_addr, ctrl_rw, ctrl_wdata, ctrl_in_valid
    );
endinterface

// File: rtl/sdram_prefetch_buffer.sv
// Single-line read prefetch buffer: critical-word-first line fill on a miss,
// one-cycle read hits, posted writes that also patch the buffered line.
module sdram_prefetch_buffer #(
    parameter int ADDR_W = 23,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    sdram_prefetch_buffer_if.slave bus,
    output logic [15:0]            stat_hits,
    output logic [15:0]            stat_misses
);
    localparam int LW = $clog2(DEPTH);
    localparam int TW = ADDR_W - LW - 2;

    typedef enum logic [1:0] {IDLE, WRITE, FILL_REQ, FILL_WAIT} state_t;

    state_t            state, state_d;
    logic              line_valid, flush_pending, miss_pend;
    logic [TW-1:0]     tag_q;
    logic [DEPTH-1:0]  word_valid;
    logic [31:0]       buf_q [DEPTH];
    logic [LW-1:0]     fidx, cnt;

    logic [LW-1:0]     widx;
    logic [TW-1:0]     tag_in;
    logic              tag_hit, rd_hit, hit, accept_wr, start_fill, word_in, fill_done;
    logic              unused_addr_lsb;

    assign widx            = bus.req_addr[LW+1:2];
    assign tag_in          = bus.req_addr[ADDR_W-1:LW+2];
    assign unused_addr_lsb = ^bus.req_addr[1:0];
    assign tag_hit         = line_valid && (tag_in == tag_q);
    assign rd_hit          = bus.req_valid && !bus.req_we && tag_hit && word_valid[widx];
    assign word_in         = (state == FILL_WAIT) && bus.ctrl_out_valid;
    assign fill_done       = word_in && (cnt == LW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d       = state;
        hit           = 1'b0;
        accept_wr     = 1'b0;
        start_fill    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid && bus.req_we) begin
                    accept_wr = 1'b1;
                    state_d   = WRITE;
                end else if (rd_hit) begin
                    hit = 1'b1;
                end else if (bus.req_valid && !flush) begin
                    // a flush in the same cycle wins; the held request misses next cycle
                    start_fill = 1'b1;
                    state_d    = FILL_REQ;
                end
            end
            WRITE:     if (!bus.ctrl_busy) state_d = IDLE;
            FILL_REQ: begin
                hit = rd_hit;
                if (!bus.ctrl_busy) state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                hit = rd_hit;
                if (word_in) state_d = fill_done ? IDLE : FILL_REQ;
            end
            default: state_d = IDLE;
        endcase
        bus.req_ready = !rst && (hit || accept_wr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid        <= 1'b0;
            flush_pending     <= 1'b0;
            miss_pend         <= 1'b0;
            tag_q             <= '0;
            word_valid        <= '0;
            fidx              <= '0;
            cnt               <= '0;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_rdata     <= '0;
            bus.ctrl_addr     <= '0;
            bus.ctrl_rw       <= 1'b0;
            bus.ctrl_wdata    <= '0;
            bus.ctrl_in_valid <= 1'b0;
            stat_hits         <= '0;
            stat_misses       <= '0;
        end else begin
            bus.rsp_valid <= hit;
            if (hit) begin
                bus.rsp_rdata <= buf_q[widx];
                // the request that caused a fill was already counted as a miss
                if (miss_pend)                   miss_pend <= 1'b0;
                else if (stat_hits != 16'hFFFF)  stat_hits <= stat_hits + 16'd1;
            end
            if (accept_wr) begin
                bus.ctrl_addr     <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                bus.ctrl_wdata    <= bus.req_wdata;
                bus.ctrl_rw       <= 1'b1;
                bus.ctrl_in_valid <= 1'b1;
            end
            if (start_fill) begin
                tag_q             <= tag_in;
                fidx              <= widx;
                cnt               <= '0;
                word_valid        <= '0;
                line_valid        <= 1'b1;
                miss_pend         <= 1'b1;
                bus.ctrl_addr     <= {tag_in, widx, 2'b00};
                bus.ctrl_rw       <= 1'b0;
                bus.ctrl_in_valid <= 1'b1;
                if (stat_misses != 16'hFFFF) stat_misses <= stat_misses + 16'd1;
            end
            if ((state == WRITE || state == FILL_REQ) && !bus.ctrl_busy)
                bus.ctrl_in_valid <= 1'b0;
            if (word_in) begin
                word_valid[fidx] <= 1'b1;
                if (!fill_done) begin
                    fidx              <= fidx + 1'b1;
                    cnt               <= cnt + 1'b1;
                    bus.ctrl_addr     <= {tag_q, fidx + 1'b1, 2'b00};
                    bus.ctrl_in_valid <= 1'b1;
                end
            end
            if (state == IDLE) begin
                if (flush) line_valid <= 1'b0;
            end else begin
                if (flush) flush_pending <= 1'b1;
                if (state_d == IDLE && (flush || flush_pending)) begin
                    line_valid    <= 1'b0;
                    flush_pending <= 1'b0;
                end
            end
        end
    end

    // Line storage needs no reset: word_valid gates every read of it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept_wr && tag_hit) buf_q[widx] <= bus.req_wdata;
            if (word_in)              buf_q[fidx] <= bus.ctrl_rdata;
        end
    end
endmodule

// File: tb/tb_sdram_prefetch_buffer.sv
// Directed bench for sdram_prefetch_buffer with a small SDRAM-controller model.
`timescale 1ns/1ps
module tb_sdram_prefetch_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] stat_hits, stat_misses;
    int          total = 0;
    int          bad = 0;

    sdram_prefetch_buffer_if #(.ADDR_W(23)) bus ();

    sdram_prefetch_buffer #(.ADDR_W(23), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus),
        .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    always #5 clk = ~clk;

    // Controller model: word i holds 0xA0+i (i<4), 0xB0+i-4 (i<8), 0xC0+i-8 (i<12).
    function automatic logic [31:0] sdram_word(input logic [3:0] i);
        return {24'h0, 4'hA + {2'b00, i[3:2]}, {2'b00, i[1:0]}};
    endfunction

    logic [23:0] log_q [$];
    logic [31:0] wr_data_seen;
    int          dly = 0;
    logic [22:0] pend_a;

    always @(negedge clk) begin
        bus.ctrl_out_valid = 1'b0;
        if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                bus.ctrl_out_valid = 1'b1;
                bus.ctrl_rdata     = sdram_word(pend_a[5:2]);
            end
        end
        if (bus.ctrl_in_valid && !bus.ctrl_busy) begin
            log_q.push_back({bus.ctrl_rw, bus.ctrl_addr});
            if (bus.ctrl_rw) wr_data_seen = bus.ctrl_wdata;
            else begin
                pend_a = bus.ctrl_addr;
                dly    = 2;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", nm, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [22:0] a, input logic [31:0] exp, input string nm,
                           output int waited);
        waited = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a;
        #1;
        while (!bus.req_ready && waited < 200) begin
            tick();
            #1;
            waited++;
        end
        chk({nm, "_ready"}, {31'h0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 1'b0;
        chk({nm, "_rsp_valid"}, {31'h0, bus.rsp_valid}, 32'd1);
        chk({nm, "_rsp_rdata"}, bus.rsp_rdata, exp);
    endtask

    task automatic wait_log(input int n, input string nm);
        int k = 0;
        while (log_q.size() < n && k < 200) begin
            tick();
            k++;
        end
        chk({nm, "_log_size"}, log_q.size(), n);
        repeat (4) tick();
    endtask

    initial begin
        int w, cnt, seen;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 23'h8;
        bus.req_wdata = 32'h0;
        bus.ctrl_busy = 1'b0;
        repeat (3) tick();
        #1;
        chk("rst_req_ready", {31'h0, bus.req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
        chk("rst_ctrl_in_valid", {31'h0, bus.ctrl_in_valid}, 32'd0);
        chk("rst_stat_hits", {16'h0, stat_hits}, 32'd0);
        chk("rst_stat_misses", {16'h0, stat_misses}, 32'd0);
        bus.req_valid = 1'b0;
        rst = 1'b0;
        tick();

        // miss at 0x08: critical word first, wrapping through the line
        do_read(23'h8, 32'hA2, "rd08", w);
        chk("rd08_missed", {31'h0, w != 0}, 32'd1);
        wait_log(4, "fill0");
        chk("fill0_a0", log_q[0], 32'h000008);
        chk("fill0_a1", log_q[1], 32'h00000C);
        chk("fill0_a2", log_q[2], 32'h000000);
        chk("fill0_a3", log_q[3], 32'h000004);
        chk("fill0_misses", {16'h0, stat_misses}, 32'd1);
        chk("fill0_hits", {16'h0, stat_hits}, 32'd0);

        // hit at 0x04
        do_read(23'h4, 32'hA1, "hit04", w);
        chk("hit04_same_cycle", w, 32'd0);
        chk("hit04_no_ctrl", {31'h0, bus.ctrl_in_valid}, 32'd0);
        chk("hit04_hits", {16'h0, stat_hits}, 32'd1);
        chk("hit04_log", log_q.size(), 32'd4);

        // posted write with the controller busy across three edges
        bus.ctrl_busy = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 23'h4;
        bus.req_wdata = 32'hDEADBEEF;
        #1;
        chk("wr_ready", {31'h0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.ctrl_in_valid && bus.ctrl_rw) cnt++;
            if (i == 3) bus.ctrl_busy = 1'b0;
            tick();
        end
        chk("wr_valid_cycles", cnt, 32'd4);
        chk("wr_log", log_q[4], 32'h800004);
        chk("wr_data", wr_data_seen, 32'hDEADBEEF);
        do_read(23'h4, 32'hDEADBEEF, "rd_after_wr", w);
        chk("rd_after_wr_hit", w, 32'd0);
        chk("rd_after_wr_hits", {16'h0, stat_hits}, 32'd2);

        // flush in IDLE, then 0x00 misses; 0x10 stalls behind that fill
        flush = 1'b1;
        tick();
        flush = 1'b0;
        do_read(23'h0, 32'hA0, "rd00", w);
        chk("rd00_missed", {31'h0, w != 0}, 32'd1);
        do_read(23'h10, 32'hB0, "rd10", w);
        chk("rd10_stalled", {31'h0, w != 0}, 32'd1);
        chk("rd10_log5", log_q[5], 32'h000000);
        chk("rd10_log8", log_q[8], 32'h00000C);
        chk("rd10_log9", log_q[9], 32'h000010);
        chk("rd10_misses", {16'h0, stat_misses}, 32'd3);
        chk("rd10_hits", {16'h0, stat_hits}, 32'd2);

        // flush while the 0x10 line is still filling
        chk("flush_midfill", {31'h0, log_q.size() < 13}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_log(13, "fill10");
        do_read(23'h14, 32'hB1, "rd14", w);
        chk("rd14_missed", {31'h0, w != 0}, 32'd1);
        chk("rd14_log", log_q[13], 32'h000014);
        chk("rd14_misses", {16'h0, stat_misses}, 32'd4);
        wait_log(17, "fill14");

        // reset while waiting for read data
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 23'h20;
        w = 0;
        while (log_q.size() < 18 && w < 50) begin
            tick();
            w++;
        end
        chk("rstfill_issued", log_q.size(), 32'd18);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        tick();
        chk("rstfill_req_ready", {31'h0, bus.req_ready}, 32'd0);
        chk("rstfill_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
        chk("rstfill_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rstfill_ctrl_in_valid", {31'h0, bus.ctrl_in_valid}, 32'd0);
        chk("rstfill_ctrl_addr", {9'h0, bus.ctrl_addr}, 32'd0);
        chk("rstfill_ctrl_rw", {31'h0, bus.ctrl_rw}, 32'd0);
        chk("rstfill_ctrl_wdata", bus.ctrl_wdata, 32'd0);
        chk("rstfill_stats", {stat_hits, stat_misses}, 32'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.rsp_valid || bus.ctrl_in_valid) seen++;
        end
        chk("rstfill_quiet", seen, 32'd0);
        chk("rstfill_log", log_q.size(), 32'd18);
        do_read(23'h20, 32'hC0, "rd20", w);
        chk("rd20_missed", {31'h0, w != 0}, 32'd1);
        chk("rd20_misses", {16'h0, stat_misses}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
